// File: rtl/spi_audio_tx.sv
// SPI mode-0 slave transmitter: queues 16-bit audio words and shifts one word
// MSB-first on MISO per active frame, sharing sclk_in/active with the receiver.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no frame; MISO tri-state (oe=0, data=0), waiting for active rise
// SHIFT    | word loaded, MISO updated after each SCLK fall, rises counted
// WAIT_END | 16 bits sent; MISO held 0, extra SCLK ignored until active falls
module spi_audio_tx #(
   parameter int          FIFO_DEPTH    = 2,
   parameter logic [15:0] UNDERRUN_WORD = 16'h0000
) (
   input  logic        clk_25mhz,
   input  logic        reset,
   input  logic        sclk_in,
   input  logic        active,
   input  logic [15:0] audio_in,
   input  logic        audio_valid,
   output logic        audio_ready,
   output logic        miso_out,
   output logic        miso_oe,
   output logic        tx_done,
   output logic        underrun,
   output logic        aborted
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;

   state_t      state;
   logic        sclk_s1, sclk_s2, sclk_d;
   logic        act_s1, act_s2, act_d;
   logic        sclk_rise, sclk_fall, act_rise, act_fall;
   logic [1:0]  sync_fill;
   logic        armed;

   logic [15:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic        fifo_full, fifo_empty, push, pop, frame_start;
   logic [15:0] head_word;

   logic [14:0] shift_reg;
   logic [4:0]  bit_cnt;

   // Edge pulses are registered, so an edge reaches the FSM 3 cycles after the pin.
   // armed waits until the synchronizer holds real pin data and active is seen low.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         sclk_s1   <= 1'b0;
         sclk_s2   <= 1'b0;
         sclk_d    <= 1'b0;
         act_s1    <= 1'b0;
         act_s2    <= 1'b0;
         act_d     <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         act_rise  <= 1'b0;
         act_fall  <= 1'b0;
         sync_fill <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sclk_s1   <= sclk_in;
         sclk_s2   <= sclk_s1;
         sclk_d    <= sclk_s2;
         act_s1    <= active;
         act_s2    <= act_s1;
         act_d     <= act_s2;
         sclk_rise <= sclk_s2 & ~sclk_d;
         sclk_fall <= ~sclk_s2 & sclk_d;
         act_rise  <= act_s2 & ~act_d;
         act_fall  <= ~act_s2 & act_d;
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && !act_s2)
            armed <= 1'b1;
      end
   end

   assign fifo_full   = (count == DEPTH_CNT);
   assign fifo_empty  = (count == '0);
   assign audio_ready = ~fifo_full;
   assign frame_start = (state == IDLE) && act_rise && armed;
   assign push        = audio_valid && !fifo_full;
   assign pop         = frame_start && !fifo_empty;
   assign head_word   = fifo_empty ? UNDERRUN_WORD : fifo_mem[rd_ptr];

   always_ff @(posedge clk_25mhz) begin
      if (push)
         fifo_mem[wr_ptr] <= audio_in;
   end

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         miso_out  <= 1'b0;
         miso_oe   <= 1'b0;
         tx_done   <= 1'b0;
         underrun  <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         underrun <= 1'b0;
         aborted  <= 1'b0;
         case (state)
            IDLE: begin
               miso_oe  <= 1'b0;
               miso_out <= 1'b0;
               if (frame_start) begin
                  shift_reg <= head_word[14:0];
                  miso_out  <= head_word[15];
                  underrun  <= fifo_empty;
                  bit_cnt   <= '0;
                  miso_oe   <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (sclk_rise && bit_cnt == 5'd15) begin
                  // last bit already sampled; a coincident active fall still ends cleanly
                  bit_cnt  <= 5'd16;
                  tx_done  <= 1'b1;
                  miso_out <= 1'b0;
                  if (act_fall) begin
                     miso_oe <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     state   <= WAIT_END;
                  end
               end else if (act_fall) begin
                  aborted  <= 1'b1;
                  miso_oe  <= 1'b0;
                  miso_out <= 1'b0;
                  state    <= IDLE;
               end else begin
                  if (sclk_rise)
                     bit_cnt <= bit_cnt + 5'd1;
                  if (sclk_fall && bit_cnt < 5'd16) begin
                     miso_out  <= shift_reg[14];
                     shift_reg <= {shift_reg[13:0], 1'b0};
                  end
               end
            end
            WAIT_END: begin
               miso_out <= 1'b0;
               if (act_fall) begin
                  miso_oe <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               miso_oe  <= 1'b0;
               miso_out <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_audio_tx.md
# spi_audio_tx

SPI slave transmitter returning processed 16-bit audio samples from the FPGA to the Pico over MISO on the same bus the `comunication` receiver listens on. It shares `sclk_in` and `active` with that receiver. It buffers words from the processing path in a small FIFO and shifts one word MSB-first per `active` frame, in SPI mode 0. The master samples on the rising SCLK edge and the block updates MISO after the falling edge.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: word FIFO depth; must be a power of 2 and ≥ 2.
- `UNDERRUN_WORD`, default 16'h0000: word sent when a frame starts with the FIFO empty.

Ports:
- `clk_25mhz` in 1: system clock, 25 MHz. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `sclk_in` in 1: SPI clock from the Pico; asynchronous.
- `active` in 1: chip select, active-high; asynchronous.
- `audio_in` in 16: sample to transmit.
- `audio_valid` in 1: `audio_in` is valid.
- `audio_ready` out 1: FIFO can accept a word; equals `!full`.
- `miso_out` out 1: serial data, MSB first.
- `miso_oe` out 1: output enable; high only while a frame is in progress.
- `tx_done` out 1: one-cycle pulse when all 16 bits of a frame have been clocked out.
- `underrun` out 1: one-cycle pulse when a frame starts with the FIFO empty.
- `aborted` out 1: one-cycle pulse when `active` falls before the 16th rising SCLK edge.

## Operation
- **Input synchronization:** `sclk_in` and `active` each pass through a 2-FF synchronizer plus one edge-detect register. Rising and falling edges are detected 3 `clk_25mhz` cycles after the pin changes.
- **FIFO:**
  - Push when `audio_valid && audio_ready`. A push at full is impossible because `audio_ready` is low.
  - Pop happens only at frame start.
  - Push and pop in the same cycle are both honored; occupancy is unchanged.
  - Frame start uses occupancy from before that cycle's push. An empty FIFO plus a same-cycle push counts as underrun, and the pushed word stays queued.
- **State machine:**
  - `IDLE`: `miso_oe` = 0 and `miso_out` = 0. On an `active` rising edge, load the shift register with the FIFO head (pop) or with `UNDERRUN_WORD` (pulse `underrun`). Then clear `bit_cnt`, drive bit 15 on `miso_out`, set `miso_oe` = 1, and go to `SHIFT`.
  - `SHIFT`: each synchronized SCLK rising edge increments `bit_cnt` (5 bits). Each SCLK falling edge with `bit_cnt` < 16 shifts left and presents the next bit.
    - When `bit_cnt` reaches 16, pulse `tx_done` and go to `WAIT_END`.
    - If `active` falls first, pulse `aborted` and go to `IDLE`. The partial word is discarded, not re-queued.
  - `WAIT_END`: `miso_out` is held 0. Extra SCLK edges are ignored. On `active` falling, go to `IDLE` and drop `miso_oe`.
- Exactly one word is sent per `active` frame; a new frame requires `active` to fall and rise again.
- **Reset:**
  - Takes effect the same cycle, even mid-frame.
  - Clears the FIFO, shift register, `bit_cnt` and synchronizers, and puts the state machine in `IDLE`.
  - Every output is 0 except `audio_ready`, which is 1.
  - After reset, `active` must be sampled low at least once before any frame start is accepted. This "armed" flag prevents a held-high `active` from starting a frame.

## Timing
- `active` pin rise to `miso_oe`/MSB valid: 4 cycles (3 cycles synchronization + 1 cycle register).
- SCLK pin fall to next bit on `miso_out`: 4 cycles.
- SCLK 16th rising edge at the pin to `tx_done`: 4 cycles.
- Master requirements:
  - ≥ 6 cycles (240 ns) from `active` rise to the first SCLK rise.
  - SCLK low and high phases each ≥ 6 cycles (240 ns). The 2 MHz SCLK gives 250 ns phases.
  - `active` held ≥ 3 cycles after the last SCLK fall.
- `audio_ready` updates the cycle after the push or pop that changes occupancy.
- Pulse outputs are exactly 1 cycle wide and registered.

## Test plan
1. Push 16'hA5A5, then run one 2 MHz frame → master samples 16'hA5A5 on the rising edges; one `tx_done` pulse; `miso_oe` high from `active` rise + 4 cycles until `active` fall + 4 cycles; no `underrun` or `aborted`.
2. Push 16'hBEEF then 16'h1234 → `audio_ready` = 0 after the second push; two frames return BEEF then 1234; `audio_ready` returns to 1 after the first frame start.
3. Frame with the FIFO empty → one `underrun` pulse; master reads 16'h0000; `tx_done` still pulses.
4. Push 16'hBEEF and 16'h1234; drop `active` after 8 SCLK rising edges → `aborted` pulse, no `tx_done`; the next full frame returns 16'h1234.
5. Assert `reset` at bit 5 of a frame with `active` still high → next cycle `miso_oe` = 0 and the FIFO is empty. Continued SCLK with `active` held high starts no frame. A later `active` low→high starts a frame that sends `UNDERRUN_WORD`.
6. Hold `audio_valid` with 3 distinct words back-to-back at depth 2 → the third word is held until the first frame start frees a slot, and is then accepted; three frames return all three words in order.
